mem_bram_responder: RTL and testbench

Memory-bus responder that answers tagged requests from the processor's memory request port out of a local block RAM. Used as a stand-in for the DRAM controller in simulation and as a small fast scratch memory in builds without external DRAM. Requests are accepted one at a time: a registered request ack (`rack_tag`) is returned for every request, and read data is returned with a registered data ack (`dack_tag`) after a configurable wait.

---
 rtl/mem_bram_responder.sv | 77 +++++++
 tb/tb_mem_bram_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_bram_responder.sv
// mem_bram_responder: tagged memory-bus responder serving one request at a time from a local block RAM
module mem_bram_responder #(
  parameter int ADDR_BITS = 12,
  parameter int BASE = 0,
  parameter int READ_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] mem_req_address,
  input  logic [3:0]  mem_req_byte_en,
  input  logic        mem_req_read_writen,
  input  logic        mem_req_request,
  input  logic [7:0]  mem_req_tag,
  input  logic [31:0] mem_req_wdata,
  output logic [7:0]  mem_resp_rack_tag,
  output logic [7:0]  mem_resp_dack_tag,
  output logic [31:0] mem_resp_data
);
  localparam int HB = 24 - ADDR_BITS;
  typedef enum logic [2:0] {IDLE, ACK, WAIT, FETCH, DATA} state_t;
  state_t state;
  logic [23:0] addr;
  logic [7:0] tag;
  logic [3:0] be;
  logic [3:0] cnt;
  logic [31:0] wdata;
  logic [31:0] ram_q;
  logic rd;
  logic hit;
  logic unused;
  logic [31:0] mem [2**ADDR_BITS];
  assign unused = ^mem_req_address[1:0];
  always_comb hit = addr[23:ADDR_BITS] == HB'(BASE);
  always_ff @(posedge clock) begin
    ram_q <= mem[addr[ADDR_BITS-1:0]];
    if (!reset && state == ACK && !rd && hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr[ADDR_BITS-1:0]][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mem_resp_rack_tag <= '0;
      mem_resp_dack_tag <= '0;
      mem_resp_data <= '0;
    end else begin
      mem_resp_rack_tag <= '0;
      mem_resp_dack_tag <= '0;
      mem_resp_data <= '0;
      case (state)
        IDLE: if (mem_req_request) begin
          addr <= mem_req_address[25:2];
          tag <= mem_req_tag;
          be <= mem_req_byte_en;
          wdata <= mem_req_wdata;
          rd <= mem_req_read_writen;
          mem_resp_rack_tag <= mem_req_tag;
          state <= ACK;
        end
        ACK: begin
          cnt <= 4'(READ_WAIT);
          state <= !rd ? IDLE : READ_WAIT > 0 ? WAIT : FETCH;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          state <= cnt == 4'd1 ? FETCH : WAIT;
        end
        FETCH: begin
          mem_resp_dack_tag <= tag;
          mem_resp_data <= hit ? ram_q : '0;
          state <= DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bram_responder.sv
// tb_mem_bram_responder: directed self-checking bench for mem_bram_responder
module tb_mem_bram_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [25:0] addr = '0;
  logic [3:0] be = '0;
  logic rw = 1'b0;
  logic [1:0] req = '0;
  logic [7:0] tag = '0;
  logic [31:0] wd = '0;
  logic [1:0][7:0] rack;
  logic [1:0][7:0] dack;
  logic [1:0][31:0] data;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  mem_bram_responder #(.ADDR_BITS(12), .BASE(0), .READ_WAIT(0)) dut0 (
    .clock(clock), .reset(reset), .mem_req_address(addr), .mem_req_byte_en(be),
    .mem_req_read_writen(rw), .mem_req_request(req[0]), .mem_req_tag(tag), .mem_req_wdata(wd),
    .mem_resp_rack_tag(rack[0]), .mem_resp_dack_tag(dack[0]), .mem_resp_data(data[0])
  );
  mem_bram_responder #(.ADDR_BITS(12), .BASE(0), .READ_WAIT(3)) dut1 (
    .clock(clock), .reset(reset), .mem_req_address(addr), .mem_req_byte_en(be),
    .mem_req_read_writen(rw), .mem_req_request(req[1]), .mem_req_tag(tag), .mem_req_wdata(wd),
    .mem_resp_rack_tag(rack[1]), .mem_resp_dack_tag(dack[1]), .mem_resp_data(data[1])
  );
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", n, o, e);
    end
  endtask
  task automatic issue(input int d, input logic r, input logic [25:0] a, input logic [3:0] b,
                       input logic [31:0] w, input logic [7:0] t);
    rw = r;
    addr = a;
    be = b;
    wd = w;
    tag = t;
    req[d] = 1'b1;
    step;
    chk("rack_tag", 32'(rack[d]), 32'(t));
    chk("dack_in_ack", 32'(dack[d]), 32'h0);
    req[d] = 1'b0;
  endtask
  task automatic write(input int d, input logic [25:0] a, input logic [3:0] b,
                       input logic [31:0] w, input logic [7:0] t);
    issue(d, 1'b0, a, b, w, t);
    step;
    chk("rack_clear_wr", 32'(rack[d]), 32'h0);
  endtask
  task automatic read(input int d, input logic [25:0] a, input logic [7:0] t,
                      input logic [31:0] e, input int waits);
    issue(d, 1'b1, a, 4'h0, 32'h0, t);
    for (int i = 0; i <= waits; i++) begin
      step;
      chk("rack_idle_rd", 32'(rack[d]), 32'h0);
      chk("dack_early", 32'(dack[d]), 32'h0);
      chk("data_early", data[d], 32'h0);
    end
    step;
    chk("dack_tag", 32'(dack[d]), 32'(t));
    chk("read_data", data[d], e);
    chk("rack_in_data", 32'(rack[d]), 32'h0);
    step;
    chk("dack_clear", 32'(dack[d]), 32'h0);
    chk("data_clear", data[d], 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    step;
    step;
    for (int d = 0; d < 2; d++) begin
      chk("reset_rack", 32'(rack[d]), 32'h0);
      chk("reset_dack", 32'(dack[d]), 32'h0);
      chk("reset_data", data[d], 32'h0);
    end
    reset = 1'b0;
    step;
    write(0, 26'h000010, 4'hF, 32'h11223344, 8'h05);
    read(0, 26'h000010, 8'h06, 32'h11223344, 0);
    write(0, 26'h000010, 4'h5, 32'hAABBCCDD, 8'h07);
    read(0, 26'h000010, 8'h08, 32'h11BB33DD, 0);
    write(0, 26'h000010, 4'h0, 32'h00000000, 8'h09);
    read(0, 26'h000010, 8'h0A, 32'h11BB33DD, 0);
    write(0, 26'h000000, 4'hF, 32'h01020304, 8'h0B);
    write(0, 26'h004000, 4'hF, 32'hFFFFFFFF, 8'h0C);
    read(0, 26'h004000, 8'h0D, 32'h00000000, 0);
    read(0, 26'h000000, 8'h0E, 32'h01020304, 0);
    rw = 1'b0;
    be = 4'hF;
    addr = 26'h000030;
    wd = 32'hA5A5A5A5;
    tag = 8'h01;
    req[0] = 1'b1;
    step;
    chk("b2b_rack1", 32'(rack[0]), 32'h01);
    addr = 26'h000034;
    wd = 32'h5A5A5A5A;
    tag = 8'h02;
    step;
    chk("b2b_gap", 32'(rack[0]), 32'h0);
    step;
    chk("b2b_rack2", 32'(rack[0]), 32'h02);
    req[0] = 1'b0;
    step;
    chk("b2b_after", 32'(rack[0]), 32'h0);
    step;
    chk("b2b_no_double", 32'(rack[0]), 32'h0);
    read(0, 26'h000030, 8'h0F, 32'hA5A5A5A5, 0);
    read(0, 26'h000034, 8'h10, 32'h5A5A5A5A, 0);
    write(0, 26'h000020, 4'hF, 32'h55667788, 8'h11);
    issue(0, 1'b0, 26'h000020, 4'hF, 32'hDEADBEEF, 8'h21);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("rst_ack_rack", 32'(rack[0]), 32'h0);
    chk("rst_ack_dack", 32'(dack[0]), 32'h0);
    chk("rst_ack_data", data[0], 32'h0);
    step;
    read(0, 26'h000020, 8'h22, 32'h55667788, 0);
    write(1, 26'h000010, 4'hF, 32'hCAFEF00D, 8'h31);
    read(1, 26'h000010, 8'h32, 32'hCAFEF00D, 3);
    issue(1, 1'b1, 26'h000010, 4'h0, 32'h0, 8'h33);
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("wait_rst_dack", 32'(dack[1]), 32'h0);
      chk("wait_rst_data", data[1], 32'h0);
      step;
    end
    read(1, 26'h000010, 8'h34, 32'hCAFEF00D, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
